// File: rtl/bus_cycle_sequencer.sv
// Two-port bus cycle sequencer for the multiplexed 8-bit address/data bus.
// Runs T1/T2/TW/T3 cycles; every output is registered from the next state.
module bus_cycle_sequencer #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata,
  output logic       err,
  output logic       busy,
  input  logic       ready,
  output logic       ALE,
  output logic       adbd,
  output logic [7:0] addr_bus,
  output logic [7:0] Data_Bus_Out,
  input  logic [7:0] Data_Bus_In,
  output logic       RD_n,
  output logic       WR_n
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(WAIT_MAX);

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} state_t;

  state_t        state, next_state;
  logic          last_grant;
  logic          cap_we;
  logic [7:0]    cap_wdata;
  logic [CW-1:0] wait_cnt, wait_cnt_next;
  logic          any_req, winner, abort, finish;

  logic       ale_d, adbd_d, rd_n_d, wr_n_d, busy_d, err_d;
  logic       gnt0_d, gnt1_d, done0_d, done1_d;
  logic [7:0] addr_bus_d, dbo_d, rdata_d;

  // Round-robin: on a tie the port that did not win last time gets the bus.
  assign any_req = req0 | req1;
  assign winner  = (req0 & req1) ? ~last_grant : req1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      wait_cnt     <= '0;
      cap_we       <= 1'b0;
      cap_wdata    <= 8'h00;
      ALE          <= 1'b0;
      adbd         <= 1'b0;
      RD_n         <= 1'b1;
      WR_n         <= 1'b1;
      busy         <= 1'b0;
      err          <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      addr_bus     <= 8'h00;
      Data_Bus_Out <= 8'h00;
      rdata        <= 8'h00;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
      if (state == IDLE && any_req) begin
        last_grant <= winner;
        cap_we     <= winner ? we1 : we0;
        cap_wdata  <= winner ? wdata1 : wdata0;
      end
      ALE          <= ale_d;
      adbd         <= adbd_d;
      RD_n         <= rd_n_d;
      WR_n         <= wr_n_d;
      busy         <= busy_d;
      err          <= err_d;
      gnt0         <= gnt0_d;
      gnt1         <= gnt1_d;
      done0        <= done0_d;
      done1        <= done1_d;
      addr_bus     <= addr_bus_d;
      Data_Bus_Out <= dbo_d;
      rdata        <= rdata_d;
    end
  end

  always_comb begin
    next_state    = state;
    wait_cnt_next = '0;
    abort         = 1'b0;
    finish        = 1'b0;
    case (state)
      IDLE: if (any_req) next_state = T1;
      T1:   next_state = T2;
      T2: begin
        if (ready) begin
          next_state = T3;
        end else if (WAIT_MAX > 0) begin
          next_state    = TW;
          wait_cnt_next = CW'(1);
        end else begin
          next_state = IDLE;
          abort      = 1'b1;
        end
      end
      TW: begin
        if (ready) begin
          next_state = T3;
        end else if (wait_cnt == WAIT_LIMIT) begin
          next_state = IDLE;
          abort      = 1'b1;
        end else begin
          next_state    = TW;
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      T3: begin
        next_state = IDLE;
        finish     = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  // Values for the cycle about to start; last_grant identifies the active port.
  always_comb begin
    ale_d      = 1'b0;
    adbd_d     = 1'b0;
    rd_n_d     = 1'b1;
    wr_n_d     = 1'b1;
    busy_d     = (next_state != IDLE);
    err_d      = 1'b0;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    addr_bus_d = addr_bus;
    dbo_d      = Data_Bus_Out;
    rdata_d    = rdata;
    case (next_state)
      T1: begin
        ale_d      = 1'b1;
        addr_bus_d = winner ? addr1 : addr0;
        gnt0_d     = ~winner;
        gnt1_d     = winner;
      end
      T2, TW: begin
        rd_n_d = cap_we;
        wr_n_d = ~cap_we;
        adbd_d = cap_we;
        if (cap_we) dbo_d = cap_wdata;
      end
      T3: begin
        rd_n_d = cap_we;
        adbd_d = cap_we;
      end
      IDLE: begin
        if (finish || abort) begin
          done0_d = ~last_grant;
          done1_d = last_grant;
          err_d   = abort;
          if (abort) rdata_d = 8'h00;
          else if (!cap_we) rdata_d = Data_Bus_In;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Self-checking bench: directed scenarios plus randomized transactions against a
// timeline model (phase of each cycle derived from wait count and WAIT_MAX).
module tb_bus_cycle_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, sel, ready;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1, Data_Bus_In;

  logic       a_req0, a_req1, b_req0, b_req1;
  logic       a_gnt0, a_gnt1, a_done0, a_done1, a_err, a_busy, a_ALE, a_adbd, a_RD_n, a_WR_n;
  logic       b_gnt0, b_gnt1, b_done0, b_done1, b_err, b_busy, b_ALE, b_adbd, b_RD_n, b_WR_n;
  logic [7:0] a_rdata, a_addr_bus, a_dbo, b_rdata, b_addr_bus, b_dbo;
  logic       o_gnt0, o_gnt1, o_done0, o_done1, o_err, o_busy, o_ALE, o_adbd, o_RD_n, o_WR_n;
  logic [7:0] o_rdata, o_addr_bus, o_dbo;

  // sel steers requests to, and observes, either the default or the WAIT_MAX=2 instance.
  assign a_req0 = req0 & ~sel;
  assign a_req1 = req1 & ~sel;
  assign b_req0 = req0 & sel;
  assign b_req1 = req1 & sel;
  assign o_gnt0 = sel ? b_gnt0 : a_gnt0;
  assign o_gnt1 = sel ? b_gnt1 : a_gnt1;
  assign o_done0 = sel ? b_done0 : a_done0;
  assign o_done1 = sel ? b_done1 : a_done1;
  assign o_err = sel ? b_err : a_err;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_ALE = sel ? b_ALE : a_ALE;
  assign o_adbd = sel ? b_adbd : a_adbd;
  assign o_RD_n = sel ? b_RD_n : a_RD_n;
  assign o_WR_n = sel ? b_WR_n : a_WR_n;
  assign o_rdata = sel ? b_rdata : a_rdata;
  assign o_addr_bus = sel ? b_addr_bus : a_addr_bus;
  assign o_dbo = sel ? b_dbo : a_dbo;

  bus_cycle_sequencer dut_a (
    .clk(clk), .reset(reset), .req0(a_req0), .req1(a_req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .done0(a_done0), .done1(a_done1), .rdata(a_rdata),
    .err(a_err), .busy(a_busy), .ready(ready), .ALE(a_ALE), .adbd(a_adbd),
    .addr_bus(a_addr_bus), .Data_Bus_Out(a_dbo), .Data_Bus_In(Data_Bus_In),
    .RD_n(a_RD_n), .WR_n(a_WR_n)
  );

  bus_cycle_sequencer #(.WAIT_MAX(2)) dut_b (
    .clk(clk), .reset(reset), .req0(b_req0), .req1(b_req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1), .rdata(b_rdata),
    .err(b_err), .busy(b_busy), .ready(ready), .ALE(b_ALE), .adbd(b_adbd),
    .addr_bus(b_addr_bus), .Data_Bus_Out(b_dbo), .Data_Bus_In(Data_Bus_In),
    .RD_n(b_RD_n), .WR_n(b_WR_n)
  );

  int         checks = 0;
  int         failures = 0;
  int         txn = 0;
  bit         ptr [2];
  logic [7:0] exp_addr [2];
  logic [7:0] exp_dbo [2];

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input bit ale, input bit g0, input bit g1,
                            input bit rdn, input bit wrn, input bit adbd, input bit busy,
                            input bit d0, input bit d1, input logic [7:0] addr,
                            input logic [7:0] dbo);
    checkOutput({tag, ".ALE"}, 8'(o_ALE), 8'(ale));
    checkOutput({tag, ".gnt0"}, 8'(o_gnt0), 8'(g0));
    checkOutput({tag, ".gnt1"}, 8'(o_gnt1), 8'(g1));
    checkOutput({tag, ".RD_n"}, 8'(o_RD_n), 8'(rdn));
    checkOutput({tag, ".WR_n"}, 8'(o_WR_n), 8'(wrn));
    checkOutput({tag, ".adbd"}, 8'(o_adbd), 8'(adbd));
    checkOutput({tag, ".busy"}, 8'(o_busy), 8'(busy));
    checkOutput({tag, ".done0"}, 8'(o_done0), 8'(d0));
    checkOutput({tag, ".done1"}, 8'(o_done1), 8'(d1));
    checkOutput({tag, ".addr_bus"}, o_addr_bus, addr);
    checkOutput({tag, ".dbo"}, o_dbo, dbo);
  endtask

  // mode 0/1 = that port alone, 2 = both request (loser withdraws after the winner's gnt).
  // waits = number of ready=0 samples starting in T2.
  task automatic applyStimulus(input int mode, input int waits, input logic [7:0] dbin);
    int         w, wm, tw, last;
    bit         abort, xwe;
    logic [7:0] xaddr, xwd;
    string      tag;
    wm = sel ? 2 : 15;
    txn++;
    req0 = (mode != 1);
    req1 = (mode != 0);
    if (mode == 2) w = (ptr[sel] == 1'b1) ? 0 : 1;
    else w = mode;
    ptr[sel] = w[0];
    xwe   = (w == 1) ? we1 : we0;
    xaddr = (w == 1) ? addr1 : addr0;
    xwd   = (w == 1) ? wdata1 : wdata0;
    exp_addr[sel] = xaddr;
    abort = (waits > wm);
    tw    = abort ? wm : waits;
    last  = abort ? 3 + tw : 4 + tw;
    for (int c = 1; c <= last; c++) begin
      bit isT1, isStr, isT3, isDone;
      @(posedge clk); #1;
      isT1   = (c == 1);
      isStr  = (c >= 2) && (c <= 2 + tw);
      isT3   = !abort && (c == 3 + tw);
      isDone = (c == last);
      if (c == 2 && xwe) exp_dbo[sel] = xwd;
      tag = $sformatf("tx%0d.c%0d", txn, c);
      checkCycle(tag, isT1, isT1 && w == 0, isT1 && w == 1,
                 !((isStr || isT3) && !xwe), !(isStr && xwe), (isStr || isT3) && xwe,
                 !isDone, isDone && w == 0, isDone && w == 1, xaddr, exp_dbo[sel]);
      if (isDone) begin
        checkOutput({tag, ".err"}, 8'(o_err), 8'(abort));
        if (abort || !xwe) checkOutput({tag, ".rdata"}, o_rdata, abort ? 8'h00 : dbin);
      end
      if (c == 1) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      ready = isStr ? ((c - 2) >= waits) : 1'($urandom_range(0, 1));
      Data_Bus_In = isT3 ? dbin : 8'($urandom);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checkCycle($sformatf("gap%0d", txn), 0, 0, 0, 1, 1, 0, 0, 0, 0, exp_addr[sel], exp_dbo[sel]);
      ready = 1'($urandom_range(0, 1));
      Data_Bus_In = 8'($urandom);
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; sel = 1'b0; ready = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00; Data_Bus_In = 8'h00;
    ptr = '{1'b1, 1'b1};
    exp_addr = '{8'h00, 8'h00};
    exp_dbo = '{8'h00, 8'h00};
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checkCycle($sformatf("reset%0d", s), 0, 0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
      checkOutput("reset.rdata", o_rdata, 8'h00);
      checkOutput("reset.err", 8'(o_err), 8'h00);
    end
    sel = 1'b0;
    reset = 1'b0;
    idleCycles(1);

    // Single read, single write, read with three wait states.
    we0 = 1'b0; addr0 = 8'h3C;
    applyStimulus(0, 0, 8'hA5);
    we1 = 1'b1; addr1 = 8'h10; wdata1 = 8'h5A;
    applyStimulus(1, 0, 8'h00);
    we0 = 1'b0; addr0 = 8'h77;
    applyStimulus(0, 3, 8'h96);

    // Timeout on the WAIT_MAX=2 instance after a good read loads rdata.
    sel = 1'b1;
    we0 = 1'b0; addr0 = 8'h44;
    applyStimulus(0, 0, 8'hC3);
    applyStimulus(0, 9, 8'h5E);
    sel = 1'b0;
    idleCycles(1);

    // Round-robin with both requests held continuously.
    we0 = 1'b0; we1 = 1'b0; addr0 = 8'hA0; addr1 = 8'hB1;
    req0 = 1'b1; req1 = 1'b1; ready = 1'b1;
    begin
      bit first, wn;
      first = ~ptr[0];
      for (int c = 1; c <= 16; c++) begin
        int ph;
        @(posedge clk); #1;
        ph = c % 4;
        wn = first ^ (((c - 1) / 4) % 2 == 1);
        checkCycle($sformatf("rr.c%0d", c), ph == 1, ph == 1 && !wn, ph == 1 && wn,
                   !(ph == 2 || ph == 3), 1, 0, ph != 0, ph == 0 && !wn, ph == 0 && wn,
                   wn ? 8'hB1 : 8'hA0, exp_dbo[0]);
        if (c == 13) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
      ptr[0] = wn;
      exp_addr[0] = wn ? 8'hB1 : 8'hA0;
    end

    // Reset asserted during TW of a write.
    we1 = 1'b1; addr1 = 8'h21; wdata1 = 8'hE7; req1 = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst.gnt1", 8'(o_gnt1), 8'h01);
    req1 = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst.T2.WR_n", 8'(o_WR_n), 8'h00);
    @(posedge clk); #1;
    checkOutput("rst.TW.WR_n", 8'(o_WR_n), 8'h00);
    checkOutput("rst.TW.dbo", o_dbo, 8'hE7);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ptr = '{1'b1, 1'b1};
    exp_addr = '{8'h00, 8'h00};
    exp_dbo = '{8'h00, 8'h00};
    checkCycle("rst.after", 0, 0, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    idleCycles(1);
    we0 = 1'b0; addr0 = 8'h5B; we1 = 1'b1; addr1 = 8'h6C; wdata1 = 8'h11;
    applyStimulus(2, 0, 8'h3D);

    // Randomized transactions on both instances.
    for (int i = 0; i < 40; i++) begin
      int wm, waits;
      sel = ($urandom_range(0, 3) == 0);
      wm = sel ? 2 : 15;
      we0 = 1'($urandom); we1 = 1'($urandom);
      addr0 = 8'($urandom); addr1 = 8'($urandom);
      wdata0 = 8'($urandom); wdata1 = 8'($urandom);
      waits = ($urandom_range(0, 6) == 0) ? wm + 1 + $urandom_range(0, 1) : $urandom_range(0, 3);
      applyStimulus($urandom_range(0, 2), waits, 8'($urandom));
      idleCycles($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_cycle_sequencer.md
# bus_cycle_sequencer

Sequences bus cycles on the shared 8-bit multiplexed address/data bus and arbitrates it between two requesters (port 0, port 1). It drives the conductor's control and data-side inputs: ALE, adbd, addr_bus and Data_Bus_Out. It collects read data from Data_Bus_In. It generates active-low RD_n/WR_n strobes, stretches cycles on an external ready line, and aborts stalled cycles after a bounded wait.

## Interface
- WAIT_MAX, default 15: maximum TW (wait) cycles before abort; 0 means no wait state is tolerated.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- req0 / req1  input  1  transaction request; held with its we/addr/wdata until the matching gnt.
- we0 / we1  input  1  1 = write, 0 = read.
- addr0 / addr1  input  8  transaction address.
- wdata0 / wdata1  input  8  write data.
- gnt0 / gnt1  output  1  one-cycle pulse: the request has been captured.
- done0 / done1  output  1  one-cycle pulse: the transaction has completed or aborted.
- rdata  output  8  read data; valid while doneN=1.
- err  output  1  valid while doneN=1; 1 = the cycle was aborted on timeout.
- busy  output  1  high in any state other than IDLE.
- ready  input  1  external device ready; sampled in T2/TW.
- ALE  output  1  address latch enable to the conductor.
- adbd  output  1  CPU drives data onto the bus (write data phase).
- addr_bus  output  8  address to the conductor.
- Data_Bus_Out  output  8  write data to the conductor.
- Data_Bus_In  input  8  read data returned from the conductor.
- RD_n / WR_n  output  1  active-low read/write strobes.

## Operation
- States: IDLE, T1, T2, TW, T3. All outputs are registered and decoded from the next state, so each output is valid for the whole cycle of its state.
- IDLE: ALE=0, adbd=0, RD_n=1, WR_n=1.
  - If any req is high, arbitrate, capture we/addr/wdata of the winner, and go to T1.
- Arbitration is round-robin on a last-grant pointer.
  - Reset pointer = 1, so port 0 wins the first tie.
  - A sole requester always wins.
  - The pointer updates to the winner.
- T1: ALE=1, addr_bus=captured addr, gntN=1 for the winner. Next state is T2.
- T2 (read): RD_n=0, adbd=0.
- T2 (write): WR_n=0, adbd=1, Data_Bus_Out=wdata.
- Ready handling in T2:
  - ready=1: go to T3.
  - ready=0 and WAIT_MAX>0: go to TW with wait count = 1.
  - ready=0 and WAIT_MAX=0: abort.
- TW: same outputs as T2.
  - ready=1: go to T3.
  - Else if count==WAIT_MAX: abort.
  - Else count+1 and stay in TW.
- T3 (read): RD_n=0. Data_Bus_In is captured into rdata at the end of T3.
- T3 (write): WR_n=1, adbd=1, Data_Bus_Out held for one cycle of hold time.
- Next state after T3 is IDLE, with doneN=1 and err=0.
- Abort: go to IDLE; doneN=1, err=1, rdata=0x00; strobes deasserted.
- addr_bus and Data_Bus_Out hold their last values in IDLE. rdata holds its value until the next done.
- A request whose reqN drops before gnt is simply not served; there is no error.

## Timing
- Reset values: ALE=0, adbd=0, RD_n=1, WR_n=1, addr_bus=0x00, Data_Bus_Out=0x00, rdata=0x00, gnt0/1=0, done0/1=0, err=0, busy=0, state=IDLE, pointer=1, wait count=0.
- Zero-wait latency: req sampled in IDLE at edge k. T1 occupies cycle k+1, T2 k+2, T3 k+3, and done is high in cycle k+4 (IDLE).
- Each TW cycle adds 1 cycle of latency.
- Back-to-back operation: a req held high during the done cycle is sampled then; T1 follows immediately, giving a minimum 4-cycle issue interval.
- Reset mid-cycle: at the next edge, state=IDLE, strobes are released, and no done pulse is issued.
- Reset overrides every other input.
- ready is ignored in IDLE, T1 and T3.

## Test plan
- Single read: req0=1, we0=0, addr0=0x3C, ready=1, Data_Bus_In=0xA5 in T3.
  - ALE=1 with addr_bus=0x3C in T1; RD_n=0 in T2–T3; done0 with rdata=0xA5 and err=0, 4 cycles after the req sample.
- Single write: req1=1, we1=1, addr1=0x10, wdata1=0x5A.
  - WR_n=0 in T2 only; adbd=1 with Data_Bus_Out=0x5A in T2–T3; done1 with err=0.
- Wait states: read with ready=0 for 3 cycles after T2.
  - Exactly 3 TW cycles with RD_n=0; done 7 cycles after the req sample; rdata correct.
- Timeout: WAIT_MAX=2, ready held 0.
  - TW lasts 2 cycles, then done0=1, err=1, rdata=0x00; strobes high in the done cycle.
- Round-robin: req0 and req1 held high continuously.
  - Grants alternate 0,1,0,1; each gnt is a single-cycle pulse; issue interval is 4 cycles.
- Reset during TW of a write.
  - Next cycle: WR_n=1, adbd=0, busy=0, no done; the following request is granted to port 0.
